pong_game_ctrl: RTL
===================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per ball step.
REQ-002 SHALL have parameter WIN_SCORE, default 7, meaning points needed to end a game.
REQ-003 SHALL have parameter SERVE_WAIT, default 120, meaning steps the ball is held before each serve.
REQ-004 SHALL have parameter PADDLE_HALF, default 40, meaning paddle half-height in pixels.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port btn_start, input, 1, meaning debounced, synchronous start level.
REQ-008 SHALL have ports ball_x and ball_y, input, 10 each, meaning current ball centre.
REQ-009 SHALL have ports paddle_l_y and paddle_r_y, input, 10 each, meaning paddle centres.
REQ-010 SHALL have port ball_load, output, 1, meaning one-cycle pulse that loads the ball to (320,240).
REQ-011 SHALL have port ball_step, output, 1, meaning one-cycle pulse that moves the ball one pixel per axis.
REQ-012 SHALL have ports dir_x and dir_y, output, 1 each, meaning 1 = +1 pixel, 0 = -1 pixel.
REQ-013 SHALL have ports score_l and score_r, output, 4 each, meaning the player scores.
REQ-014 SHALL have port state, output, 3, meaning the current FSM state encoding.
REQ-015 SHALL have port game_over, output, 1, meaning high while in the OVER state.

Function
REQ-016 SHALL use a free-running step counter, 0..TICK_DIV-1, whose terminal count ("tick") is a one-cycle internal strobe.
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; the encodings 5-7 SHALL go to IDLE.
REQ-018 SHALL move IDLE->SERVE on a btn_start rising edge, detected against a registered copy of btn_start; on this transition both scores SHALL clear and ball_load SHALL pulse.
REQ-019 SHALL count SERVE_WAIT ticks in SERVE, then go to PLAY; ball_step SHALL stay low throughout SERVE.
REQ-020 In PLAY, on every tick: compute the new dir_x/dir_y and register ball_step=1, so the ball moves the following cycle using the new directions.
REQ-021 SHALL set dir_y=0 when ball_y>=480 and dir_y=1 when ball_y<=10; when neither holds, dir_y SHALL hold its value.
REQ-022 Left edge (ball_x<=70): if |ball_y-paddle_l_y|<=PADDLE_HALF, SHALL set dir_x=1; otherwise SHALL increment score_r and go to POINT.
REQ-023 Right edge (ball_x>=580): if |ball_y-paddle_r_y|<=PADDLE_HALF, SHALL set dir_x=0; otherwise SHALL increment score_l and go to POINT.
REQ-024 The paddle distance SHALL be computed as an unsigned 10-bit magnitude (larger minus smaller), never as a wrapped subtraction.
REQ-025 A corner hit SHALL apply the x and y rules in the same tick; a miss takes priority over any y change.
REQ-026 On a miss tick, ball_step SHALL NOT be asserted.
REQ-027 POINT SHALL last one cycle: if the incremented score equals WIN_SCORE, go to OVER; otherwise pulse ball_load and go to SERVE.
REQ-028 On each serve, dir_x SHALL point toward the player who lost the point, and dir_y SHALL toggle.
REQ-029 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-030 In OVER, the ball SHALL be frozen; a btn_start rising edge SHALL act as in REQ-018.
REQ-031 A btn_start edge in SERVE, PLAY or POINT SHALL be ignored.

Reset
REQ-032 While rst_n=0, SHALL hold state=IDLE, scores=0, dir_x=1, dir_y=1, ball_load=0, ball_step=0, game_over=0, all counters=0, and the btn_start register=0.
REQ-033 Reset asserted mid-PLAY SHALL take effect immediately (asynchronously); after release the block SHALL wait in IDLE for btn_start.

Structure
REQ-034 The state encodings and the field constants (70, 580, 10, 480, 320, 240) SHALL live in the shared package pong_pkg.
REQ-035 The step counter SHALL be the sub-module tick_gen (parameter TICK_DIV, output tick).

Verification
REQ-036 Start test: TICK_DIV=4, SERVE_WAIT=3, pulse btn_start -> ball_load for 1 cycle, state=SERVE, then state=PLAY after 3 ticks, with no ball_step before that.
REQ-037 Wall test: ball_y=480, dir_y=1, at a tick -> dir_y=0, and ball_step pulses the next cycle.
REQ-038 Paddle hit test: ball_x=70, ball_y=200, paddle_l_y=240 -> dir_x=1, scores unchanged; repeat with paddle_l_y=241 -> score_r+1, state=POINT, then SERVE with dir_x=0.
REQ-039 Game-end test: score_l=6 and a right-edge miss -> score_l=7, state=OVER, game_over=1; a further miss is impossible and ball_step stays 0.
REQ-040 Reset test: assert rst_n=0 mid-PLAY on a tick cycle -> all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings, playfield constants and
// small arithmetic helpers used by the game controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [9:0] X_LEFT   = 10'd70;
    localparam logic [9:0] X_RIGHT  = 10'd580;
    localparam logic [9:0] Y_TOP    = 10'd10;
    localparam logic [9:0] Y_BOTTOM = 10'd480;
    localparam logic [9:0] X_CENTRE = 10'd320;
    localparam logic [9:0] Y_CENTRE = 10'd240;

    // Magnitude of the difference: larger minus smaller, so it can never wrap.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s < lim) ? (s + 4'd1) : s;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the terminal count
// as a one-cycle tick strobe.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score sequencing, wall and paddle
// bounces, and the ball load/step strobes that drive the ball datapath.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_WAIT  = 120,
    parameter int PADDLE_HALF = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic       ball_load,
    output logic       ball_step,
    output logic       dir_x,
    output logic       dir_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       game_over
);

    localparam int SW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_WAIT - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
    localparam logic [9:0]    HALF       = 10'(PADDLE_HALF);

    logic          tick;
    logic [2:0]    state_q, state_d;
    logic          btn_q;
    logic [SW-1:0] serve_cnt_q, serve_cnt_d;
    logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic          load_q, load_d, step_q, step_d;

    logic start_edge, at_left, at_right, miss_l, miss_r, serve_done, won;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign start_edge = btn_start & ~btn_q;
    assign at_left    = (ball_x <= X_LEFT);
    assign at_right   = (ball_x >= X_RIGHT);
    assign miss_l     = at_left  && (abs_diff(ball_y, paddle_l_y) > HALF);
    assign miss_r     = at_right && (abs_diff(ball_y, paddle_r_y) > HALF);
    assign serve_done = tick && (serve_cnt_q == SERVE_LAST);
    assign won        = (score_l_q == WIN) || (score_r_q == WIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (start_edge) state_d = ST_SERVE;
            ST_SERVE:         if (serve_done) state_d = ST_PLAY;
            ST_PLAY:          if (tick && (miss_l || miss_r)) state_d = ST_POINT;
            ST_POINT:         state_d = won ? ST_OVER : ST_SERVE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; a miss suppresses the step and any y bounce.
    always_comb begin
        serve_cnt_d = serve_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        load_d      = 1'b0;
        step_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_cnt_d = '0;
                    load_d      = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick) serve_cnt_d = serve_done ? '0 : serve_cnt_q + 1'b1;
            end
            ST_PLAY: begin
                if (tick) begin
                    if (miss_l) begin
                        score_r_d = sat_inc(score_r_q, WIN);
                        dir_x_d   = 1'b0;
                    end else if (miss_r) begin
                        score_l_d = sat_inc(score_l_q, WIN);
                        dir_x_d   = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        if (ball_y >= Y_BOTTOM)  dir_y_d = 1'b0;
                        else if (ball_y <= Y_TOP) dir_y_d = 1'b1;
                        if (at_left)  dir_x_d = 1'b1;
                        if (at_right) dir_x_d = 1'b0;
                    end
                end
            end
            ST_POINT: begin
                if (!won) begin
                    load_d  = 1'b1;
                    dir_y_d = ~dir_y_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            serve_cnt_q <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            load_q      <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            btn_q       <= btn_start;
            serve_cnt_q <= serve_cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            load_q      <= load_d;
            step_q      <= step_d;
        end
    end

    always_comb begin
        state     = state_q;
        game_over = (state_q == ST_OVER);
        ball_load = load_q;
        ball_step = step_q;
        dir_x     = dir_x_q;
        dir_y     = dir_y_q;
        score_l   = score_l_q;
        score_r   = score_r_q;
    end

endmodule
